// File: rtl/uart_seq_pkg.sv
// Shared definitions for the UART transaction sequencer: FSM states and
// the bit positions inside the UART status byte.
package uart_seq_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    TX_WAIT  = 4'd1,
    TX_WR    = 4'd2,
    TX_GAP   = 4'd3,
    TX_DRAIN = 4'd4,
    RX_WAIT  = 4'd5,
    RX_RD    = 4'd6,
    RX_CAP   = 4'd7,
    DONE     = 4'd8
  } seq_state_e;

  localparam int BUF_FULL   = 0;
  localparam int RX_RUN     = 5;
  localparam int TX_PENDING = 6;
  localparam int TX_RUN     = 7;

endpackage

// File: rtl/uart_seq_timer.sv
// Per-byte receive timeout counter. Counts enabled cycles since the last
// clear; expired is raised once the count equals a nonzero limit. A zero
// limit means "never expire".
module uart_seq_timer #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;

  assign expired = (limit != '0) && (cnt_q == limit);

  // Count while enabled; hold once expired so the count never wraps past the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

endmodule

// File: rtl/uart_transaction_sequencer.sv
// Sequences one host command into a burst of UART writes followed by a
// burst of UART reads, with a per-byte receive timeout.
//
// Host TX handshake: a byte moves when txValid & txReady are both high on a
// rising edge; txData must be stable while txValid is high, txReady only
// rises in TX_WAIT and never while the registered bufferFull bit is set.
module uart_transaction_sequencer
  import uart_seq_pkg::*;
#(
  parameter int TIMEOUT_WIDTH = 24,
  parameter int LEN_WIDTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmdStart,
  input  logic [LEN_WIDTH-1:0]     cmdTxLen,
  input  logic [LEN_WIDTH-1:0]     cmdRxLen,
  input  logic [TIMEOUT_WIDTH-1:0] rxTimeout,
  input  logic [7:0]               txData,
  input  logic                     txValid,
  output logic                     txReady,
  output logic [7:0]               rxData,
  output logic                     rxValid,
  output logic                     busy,
  output logic                     done,
  output logic                     timeoutErr,
  output logic [7:0]               uartDataIn,
  output logic                     uartNWe,
  output logic                     uartNCsData,
  input  logic [7:0]               uartDataOut,
  input  logic [7:0]               uartStatus,
  output logic [3:0]               dbgState,
  output logic [7:0]               dbgStatus
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  seq_state_e               state_q, state_d;
  logic [7:0]               status_q;
  logic [LEN_WIDTH-1:0]     tx_rem_q, tx_rem_d;
  logic [LEN_WIDTH-1:0]     rx_rem_q, rx_rem_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic [7:0]               din_q, din_d;
  logic [7:0]               rxd_q, rxd_d;
  logic                     to_err_q, to_err_d;
  logic                     tmr_clear, tmr_enable, tmr_expired;

  assign busy       = (state_q != IDLE);
  assign uartDataIn = din_q;
  assign rxData     = rxd_q;
  assign dbgState   = state_q;
  assign dbgStatus  = status_q;
  assign tmr_clear  = (state_q != RX_WAIT);
  assign tmr_enable = (state_q == RX_WAIT);

  uart_seq_timer #(.WIDTH(TIMEOUT_WIDTH)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .limit   (tmo_q),
    .expired (tmr_expired)
  );

  // State, latched command, held data bytes and the single status register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      status_q <= '0;
      tx_rem_q <= '0;
      rx_rem_q <= '0;
      tmo_q    <= '0;
      din_q    <= '0;
      rxd_q    <= '0;
      to_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= uartStatus;
      tx_rem_q <= tx_rem_d;
      rx_rem_q <= rx_rem_d;
      tmo_q    <= tmo_d;
      din_q    <= din_d;
      rxd_q    <= rxd_d;
      to_err_q <= to_err_d;
    end
  end

  // Next-state and Moore outputs; every decision uses status_q, never uartStatus.
  always_comb begin
    state_d     = state_q;
    tx_rem_d    = tx_rem_q;
    rx_rem_d    = rx_rem_q;
    tmo_d       = tmo_q;
    din_d       = din_q;
    rxd_d       = rxd_q;
    to_err_d    = to_err_q;
    txReady     = 1'b0;
    rxValid     = 1'b0;
    done        = 1'b0;
    timeoutErr  = 1'b0;
    uartNWe     = 1'b1;
    uartNCsData = 1'b1;
    case (state_q)
      IDLE: begin
        if (cmdStart) begin
          tx_rem_d = cmdTxLen;
          rx_rem_d = cmdRxLen;
          tmo_d    = rxTimeout;
          to_err_d = 1'b0;
          if (cmdTxLen != '0)      state_d = TX_WAIT;
          else if (cmdRxLen != '0) state_d = RX_WAIT;
          else                     state_d = DONE;
        end
      end
      TX_WAIT: begin
        txReady = !status_q[BUF_FULL];
        if (txValid && !status_q[BUF_FULL]) begin
          din_d   = txData;
          state_d = TX_WR;
        end
      end
      TX_WR: begin
        uartNWe = 1'b0;
        if (tx_rem_q != '0) tx_rem_d = tx_rem_q - LEN_ONE;
        state_d = TX_GAP;
      end
      TX_GAP: begin
        // One idle cycle so status_q reflects the write just issued.
        state_d = (tx_rem_q != '0) ? TX_WAIT : TX_DRAIN;
      end
      TX_DRAIN: begin
        if (!status_q[TX_PENDING] && !status_q[TX_RUN]) begin
          state_d = (rx_rem_q != '0) ? RX_WAIT : DONE;
        end
      end
      RX_WAIT: begin
        // A byte arriving in the expiry cycle still wins.
        if (status_q[BUF_FULL]) begin
          state_d = RX_RD;
        end else if (tmr_expired) begin
          to_err_d = 1'b1;
          state_d  = DONE;
        end
      end
      RX_RD: begin
        uartNCsData = 1'b0;
        rxd_d       = uartDataOut;
        if (rx_rem_q != '0) rx_rem_d = rx_rem_q - LEN_ONE;
        state_d = RX_CAP;
      end
      RX_CAP: begin
        rxValid = 1'b1;
        state_d = (rx_rem_q != '0) ? RX_WAIT : DONE;
      end
      DONE: begin
        done       = 1'b1;
        timeoutErr = to_err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_transaction_sequencer.sv
// Bench for uart_transaction_sequencer: a behavioural UART peer, a host TX
// driver, and a scoreboard comparing written/read bytes and completion.
module tb_uart_transaction_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        cmdStart;
  logic [3:0]  cmdTxLen, cmdRxLen;
  logic [23:0] rxTimeout;
  logic [7:0]  txData;
  logic        txValid, txReady;
  logic [7:0]  rxData;
  logic        rxValid, busy, done, timeoutErr;
  logic [7:0]  uartDataIn;
  logic        uartNWe, uartNCsData;
  logic [7:0]  uartDataOut, uartStatus;
  logic [3:0]  dbgState;
  logic [7:0]  dbgStatus;

  uart_transaction_sequencer dut (
    .clk(clk), .reset(reset), .cmdStart(cmdStart), .cmdTxLen(cmdTxLen),
    .cmdRxLen(cmdRxLen), .rxTimeout(rxTimeout), .txData(txData),
    .txValid(txValid), .txReady(txReady), .rxData(rxData), .rxValid(rxValid),
    .busy(busy), .done(done), .timeoutErr(timeoutErr), .uartDataIn(uartDataIn),
    .uartNWe(uartNWe), .uartNCsData(uartNCsData), .uartDataOut(uartDataOut),
    .uartStatus(uartStatus), .dbgState(dbgState), .dbgStatus(dbgStatus)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];     // bytes the host offers, in order
  logic [7:0] tx_src[$];    // bytes still to be offered
  logic [7:0] tx_log[$];    // bytes the peer saw written
  logic [7:0] peer_rx[$];   // bytes the peer will answer with
  logic [7:0] exp_rx_q[$];  // bytes expected on rxData
  logic [7:0] rx_got[$];    // bytes seen on rxData

  int   tx_busy, rx_delay, cur_tx_len, cyc, done_cyc;
  bit   released, done_seen, to_seen, prev_done, prev_rxv;
  bit   obs_xfer, obs_wr, obs_rd;
  logic [7:0] stat_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // The peer's status byte as the sequencer will see it one clock later.
  always @(posedge clk or posedge reset) begin
    if (reset) stat_q <= 8'h00;
    else       stat_q <= uartStatus;
  end

  // ---------------- driver / peer tasks ----------------
  task automatic drive_tx();
    if (tx_src.size() > 0 && $urandom_range(0, 3) != 0) begin
      txValid = 1'b1;
      txData  = tx_src[0];
    end else begin
      txValid = 1'b0;
      txData  = 8'($urandom);
    end
  endtask

  task automatic drive_uart();
    bit avail;
    avail       = released && rx_delay == 0 && peer_rx.size() > 0;
    uartDataOut = (peer_rx.size() > 0) ? peer_rx[0] : 8'h00;
    uartStatus  = {tx_busy > 0, tx_busy > 1, released && rx_delay > 0, 4'b0000,
                   (tx_busy > 0) || avail};
  endtask

  task automatic clear_model();
    exp_q.delete(); tx_src.delete(); tx_log.delete();
    peer_rx.delete(); exp_rx_q.delete(); rx_got.delete();
    tx_busy = 0; rx_delay = 0; released = 1'b0; done_seen = 1'b0;
    to_seen = 1'b0; cyc = 0; done_cyc = -1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_src.push_back(b); exp_q.push_back(b);
  endtask

  task automatic push_rx(input logic [7:0] b);
    peer_rx.push_back(b); exp_rx_q.push_back(b);
  endtask

  // Observe one cycle at the falling edge and run the per-cycle invariants.
  task automatic observe();
    @(negedge clk);
    check_eq("strobe_excl", 32'(!uartNWe && !uartNCsData), 0);
    check_eq("txready_vs_status", 32'(txReady && stat_q[0]), 0);
    check_eq("rd_before_drain", 32'(!uartNCsData && tx_busy > 0), 0);
    check_eq("done_width", 32'(done && prev_done), 0);
    check_eq("rxvalid_width", 32'(rxValid && prev_rxv), 0);
    obs_xfer = txValid && txReady;
    obs_wr   = !uartNWe;
    obs_rd   = !uartNCsData;
    if (obs_wr) tx_log.push_back(uartDataIn);
    if (rxValid) rx_got.push_back(rxData);
    if (done && !done_seen) begin
      done_seen = 1'b1; done_cyc = cyc; to_seen = timeoutErr;
    end
    prev_done = done;
    prev_rxv  = rxValid;
  endtask

  // Cross the rising edge and update the host/peer models from what was observed.
  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    if (obs_xfer && tx_src.size() > 0) void'(tx_src.pop_front());
    if (tx_busy > 0) tx_busy--;
    if (obs_wr) tx_busy = $urandom_range(1, 6);
    if (!released && tx_log.size() == cur_tx_len && tx_busy == 0) begin
      released = 1'b1;
      rx_delay = $urandom_range(0, 15);
    end else if (released && rx_delay > 0) begin
      rx_delay--;
    end
    if (obs_rd) begin
      if (peer_rx.size() > 0) void'(peer_rx.pop_front());
      rx_delay = $urandom_range(1, 15);
    end
    drive_tx();
    drive_uart();
  endtask

  // One command from start to done; queues must already be filled.
  task automatic run_txn(input int tx_len, input int rx_len, input int tmo,
                         input int inject_at, input bit exp_to);
    cur_tx_len = tx_len;
    drive_tx(); drive_uart();
    cmdStart = 1'b1; cmdTxLen = 4'(tx_len); cmdRxLen = 4'(rx_len); rxTimeout = 24'(tmo);
    observe(); advance();
    cmdStart = 1'b0; cmdTxLen = 4'($urandom); cmdRxLen = 4'($urandom); rxTimeout = 24'($urandom);
    while (!done_seen && cyc < 20000) begin
      if (cyc == inject_at) begin
        cmdStart = 1'b1; cmdTxLen = 4'($urandom); cmdRxLen = 4'($urandom); rxTimeout = 24'd1;
      end
      observe(); advance();
      cmdStart = 1'b0;
    end
    check_eq("done_seen", 32'(done_seen), 1);
    check_eq("tx_count", 32'(tx_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      check_eq("tx_byte", 32'(tx_log[i]), 32'(exp_q[i]));
    check_eq("rx_count", 32'(rx_got.size()), 32'(exp_rx_q.size()));
    for (int i = 0; i < exp_rx_q.size() && i < rx_got.size(); i++)
      check_eq("rx_byte", 32'(rx_got[i]), 32'(exp_rx_q[i]));
    check_eq("timeout_err", 32'(to_seen), 32'(exp_to));
    observe();
    check_eq("busy_after_done", 32'(busy), 0);
    advance();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int tx_len, rx_len, supply, tmo;
    reset = 1'b1; cmdStart = 1'b0; cmdTxLen = '0; cmdRxLen = '0; rxTimeout = '0;
    txValid = 1'b0; txData = '0; prev_done = 1'b0; prev_rxv = 1'b0;
    clear_model(); cur_tx_len = 0; drive_uart();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_timeout", 32'(timeoutErr), 0);
    check_eq("rst_rxvalid", 32'(rxValid), 0);
    check_eq("rst_txready", 32'(txReady), 0);
    check_eq("rst_nwe", 32'(uartNWe), 1);
    check_eq("rst_ncs", 32'(uartNCsData), 1);
    check_eq("rst_datain", 32'(uartDataIn), 0);
    check_eq("rst_rxdata", 32'(rxData), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Three-byte write, no read.
    clear_model();
    push_tx(8'h3B); push_tx(8'h97); push_tx(8'h12);
    run_txn(3, 0, 0, -1, 1'b0);

    // One byte out, two answered back.
    clear_model();
    push_tx(8'h55); push_rx(8'h56); push_rx(8'h78);
    run_txn(1, 2, 0, -1, 1'b0);

    // Silent peer: timeout after 500 cycles of waiting (wait starts one cycle after start).
    clear_model();
    run_txn(0, 1, 500, -1, 1'b1);
    check_eq("timeout_latency", 32'((done_cyc - 1) >= 498 && (done_cyc - 1) <= 502), 1);

    // Empty command; a second start during the done cycle must be ignored.
    clear_model();
    run_txn(0, 0, 0, 1, 1'b0);
    check_eq("empty_latency", 32'(done_cyc >= 1 && done_cyc <= 2), 1);

    // Start ignored while busy mid-transfer.
    clear_model();
    for (int i = 0; i < 4; i++) push_tx(8'($urandom));
    push_rx(8'($urandom));
    run_txn(4, 1, 0, 3, 1'b0);

    // Maximum lengths.
    clear_model();
    for (int i = 0; i < 15; i++) begin push_tx(8'($urandom)); push_rx(8'($urandom)); end
    run_txn(15, 15, 100, -1, 1'b0);

    // Reset while a write strobe is low.
    clear_model();
    for (int i = 0; i < 3; i++) push_tx(8'($urandom));
    cur_tx_len = 3; drive_tx(); drive_uart();
    cmdStart = 1'b1; cmdTxLen = 4'd3; cmdRxLen = 4'd0; rxTimeout = '0;
    for (int k = 0; k < 200; k++) begin
      observe();
      if (obs_wr) break;
      advance();
      cmdStart = 1'b0;
    end
    cmdStart = 1'b0;
    check_eq("reached_tx_wr", 32'(obs_wr), 1);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_nwe", 32'(uartNWe), 1);
    check_eq("abort_ncs", 32'(uartNCsData), 1);
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_done", 32'(done), 0);
    @(posedge clk); #1;
    clear_model(); cur_tx_len = 0; drive_tx(); drive_uart();
    reset = 1'b0;
    @(posedge clk); #1;
    clear_model();
    push_tx(8'hA5); push_tx(8'h5A); push_rx(8'hC3);
    run_txn(2, 1, 0, -1, 1'b0);

    // Randomized commands.
    for (int t = 0; t < 25; t++) begin
      clear_model();
      tx_len = $urandom_range(0, 5);
      rx_len = $urandom_range(0, 4);
      tmo    = ($urandom_range(0, 1) != 0) ? $urandom_range(40, 80) : 0;
      supply = rx_len;
      if (tmo != 0 && rx_len > 0 && $urandom_range(0, 2) == 0) supply = $urandom_range(0, rx_len - 1);
      for (int i = 0; i < tx_len; i++) push_tx(8'($urandom));
      for (int i = 0; i < supply; i++) push_rx(8'($urandom));
      run_txn(tx_len, rx_len, tmo, (tx_len > 0) ? 3 : -1, supply < rx_len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
